// File: rtl/key_event_ctrl_pkg.sv
// Shared definitions for the key event controller.
//  - key_state_e : per-channel debounce/classification state encoding
//  - EVT_*_FLD   : field index of each event class inside evt_flags; the
//                  field occupies bits [fld*NUM_KEYS +: NUM_KEYS]
package key_event_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_WAIT = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_LONG       = 3'd3,
    ST_REL_WAIT   = 3'd4
  } key_state_e;

  localparam int EVT_PRESS_FLD = 0;
  localparam int EVT_REL_FLD   = 1;
  localparam int EVT_LONG_FLD  = 2;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Key pins, event outputs and sticky flag handshake of the key event controller.
//  master : the side owning the key pins and the clear mask (board / M3)
//  slave  : key_event_ctrl
//  key_n      raw active-low key pins
//  evt_clr    write-1-to-clear mask for evt_flags
//  key_level  debounced level, 1 = held
//  key_press  / key_long / key_rel  1-cycle event pulses
//  evt_flags  sticky flags {long, rel, press}
interface key_event_ctrl_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0]   key_n;
  logic [3*NUM_KEYS-1:0] evt_clr;
  logic [NUM_KEYS-1:0]   key_level;
  logic [NUM_KEYS-1:0]   key_press;
  logic [NUM_KEYS-1:0]   key_long;
  logic [NUM_KEYS-1:0]   key_rel;
  logic [3*NUM_KEYS-1:0] evt_flags;

  modport master (
    output key_n, evt_clr,
    input  key_level, key_press, key_long, key_rel, evt_flags
  );

  modport slave (
    input  key_n, evt_clr,
    output key_level, key_press, key_long, key_rel, evt_flags
  );
endinterface

// File: rtl/key_event_ctrl_chan.sv
// key_event_chan: one key channel -- 2-flop synchronizer, debounce /
// long-press FSM, debounce and hold counters, registered event pulses.
//  clk, rst   clock, synchronous active-high reset
//  key_n      raw active-low key pin (asynchronous)
//  key_level  debounced level (1 in PRESSED, LONG, REL_WAIT)
//  key_press / key_long / key_rel  registered 1-cycle pulses
module key_event_chan
  import key_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 3240000,
  parameter int LONG_CYC     = 324000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_long,
  output logic key_rel
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v >= HOLD_MAX) ? v : v + 1'b1;
  endfunction

  logic              key_n_p0, key_n_p1;
  logic              s;
  key_state_e        state, state_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              long_seen, long_seen_nxt;
  logic              press_nxt, long_nxt, rel_nxt;

  // Stage p0/p1: synchronizer; resets to released so no press on reset exit
  always_ff @(posedge clk) begin
    if (rst) begin
      key_n_p0 <= 1'b1;
      key_n_p1 <= 1'b1;
    end else begin
      key_n_p0 <= key_n;
      key_n_p1 <= key_n_p0;
    end
  end

  assign s = ~key_n_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:       if (s) state_nxt = ST_PRESS_WAIT;
      ST_PRESS_WAIT: begin
        if (!s)                        state_nxt = ST_IDLE;
        else if (deb_cnt == DEB_LAST)  state_nxt = ST_PRESSED;
      end
      // Release-start has priority over the long-press threshold.
      ST_PRESSED: begin
        if (!s)                        state_nxt = ST_REL_WAIT;
        else if (hold_cnt >= HOLD_LAST) state_nxt = ST_LONG;
      end
      ST_LONG:       if (!s) state_nxt = ST_REL_WAIT;
      ST_REL_WAIT: begin
        if (s)                         state_nxt = long_seen ? ST_LONG : ST_PRESSED;
        else if (deb_cnt == DEB_LAST)  state_nxt = ST_IDLE;
      end
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // hold_cnt counts every cycle spent in PRESSED (including the one that
  // starts a release), so a release glitch delays key_long by exactly the
  // number of cycles spent outside PRESSED.
  always_comb begin
    deb_cnt_nxt   = deb_cnt;
    hold_cnt_nxt  = hold_cnt;
    long_seen_nxt = long_seen;
    press_nxt     = 1'b0;
    long_nxt      = 1'b0;
    rel_nxt       = 1'b0;
    unique case (state)
      ST_IDLE:       if (s) deb_cnt_nxt = '0;
      ST_PRESS_WAIT: begin
        if (s) begin
          if (deb_cnt == DEB_LAST) begin
            press_nxt    = 1'b1;
            hold_cnt_nxt = '0;
          end else begin
            deb_cnt_nxt = deb_cnt + 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        hold_cnt_nxt = hold_sat_inc(hold_cnt);
        if (!s)                         deb_cnt_nxt = '0;
        else if (hold_cnt >= HOLD_LAST) long_nxt    = 1'b1;
      end
      ST_LONG: begin
        if (!s) begin
          deb_cnt_nxt   = '0;
          long_seen_nxt = 1'b1;
        end
      end
      ST_REL_WAIT: begin
        if (!s) begin
          if (deb_cnt == DEB_LAST) begin
            rel_nxt       = 1'b1;
            long_seen_nxt = 1'b0;
          end else begin
            deb_cnt_nxt = deb_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Stage p2: counters and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_seen <= 1'b0;
      key_press <= 1'b0;
      key_long  <= 1'b0;
      key_rel   <= 1'b0;
    end else begin
      deb_cnt   <= deb_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      long_seen <= long_seen_nxt;
      key_press <= press_nxt;
      key_long  <= long_nxt;
      key_rel   <= rel_nxt;
    end
  end

  assign key_level = (state == ST_PRESSED) || (state == ST_LONG) || (state == ST_REL_WAIT);

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounces NUM_KEYS active-low pushbuttons and classifies
// press / long-press / release, with sticky event flags for the M3.
//  clk  fabric clock (clk_324 at top level)
//  rst  synchronous active-high reset
//  bus  key_event_ctrl_if.slave: key_n, evt_clr in; key_level, key_press,
//       key_long, key_rel, evt_flags out
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int NUM_KEYS     = 2,
  parameter int DEBOUNCE_CYC = 3240000,
  parameter int LONG_CYC     = 324000000
) (
  input  logic             clk,
  input  logic             rst,
  key_event_ctrl_if.slave  bus
);

  logic [NUM_KEYS-1:0]   level, press, long_evt, rel;
  logic [3*NUM_KEYS-1:0] evt_set;
  logic [3*NUM_KEYS-1:0] flags;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_event_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .key_n     (bus.key_n[i]),
      .key_level (level[i]),
      .key_press (press[i]),
      .key_long  (long_evt[i]),
      .key_rel   (rel[i])
    );
  end

  always_comb begin
    evt_set = '0;
    evt_set[EVT_PRESS_FLD*NUM_KEYS +: NUM_KEYS] = press;
    evt_set[EVT_REL_FLD*NUM_KEYS   +: NUM_KEYS] = rel;
    evt_set[EVT_LONG_FLD*NUM_KEYS  +: NUM_KEYS] = long_evt;
  end

  // Sticky flags: a pulse arriving together with its clear bit wins.
  always_ff @(posedge clk) begin
    if (rst) flags <= '0;
    else     flags <= (flags & ~bus.evt_clr) | evt_set;
  end

  assign bus.key_level = level;
  assign bus.key_press = press;
  assign bus.key_long  = long_evt;
  assign bus.key_rel   = rel;
  assign bus.evt_flags = flags;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Testbench for key_event_ctrl: directed scenarios plus randomized key
// traffic, checked against a run-length based reference model through an
// event scoreboard.
module tb_key_event_ctrl;
  localparam int N  = 2;
  localparam int D  = 8;
  localparam int L  = 40;
  localparam int FW = 3 * N;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_event_ctrl_if #(.NUM_KEYS(N)) bus ();

  key_event_ctrl #(
    .NUM_KEYS     (N),
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; int ch; int kind; } evt_t;
  evt_t exp_q[$];

  // reference model state
  bit          ms0 [N];
  bit          ms1 [N];
  int          opp_run [N];
  bit          m_pressed [N];
  bit          m_long [N];
  int          hold [N];
  logic [FW-1:0] m_flags;
  logic [FW-1:0] m_pulse_prev;
  logic [N-1:0]  m_level;

  int last_cyc  [3][N];
  int cnt_pulse [3][N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a key is accepted as pressed/released once the
  // synchronized sample has disagreed with the debounced level for D+1
  // consecutive edges; hold time accrues only while no release run is open.
  initial begin
    forever begin
      logic [FW-1:0] pulse_now;
      @(posedge clk);
      cyc++;
      pulse_now = '0;
      if (rst) begin
        for (int ch = 0; ch < N; ch++) begin
          ms0[ch] = 1'b1; ms1[ch] = 1'b1;
          opp_run[ch] = 0; m_pressed[ch] = 1'b0; m_long[ch] = 1'b0; hold[ch] = 0;
        end
        m_flags = '0;
      end else begin
        m_flags = (m_flags & ~bus.evt_clr) | m_pulse_prev;
        for (int ch = 0; ch < N; ch++) begin
          bit s;
          int ev;
          s  = ~ms1[ch];
          ms1[ch] = ms0[ch];
          ms0[ch] = bus.key_n[ch];
          ev = -1;
          if (!m_pressed[ch]) begin
            opp_run[ch] = s ? opp_run[ch] + 1 : 0;
            if (opp_run[ch] == D + 1) begin
              m_pressed[ch] = 1'b1; m_long[ch] = 1'b0;
              opp_run[ch] = 0; hold[ch] = 0; ev = K_PRESS;
            end
          end else begin
            if (opp_run[ch] == 0 && !m_long[ch]) begin
              if (s && hold[ch] >= L - 1) begin
                m_long[ch] = 1'b1; ev = K_LONG;
              end
              if (hold[ch] < L) hold[ch]++;
            end
            opp_run[ch] = s ? 0 : opp_run[ch] + 1;
            if (opp_run[ch] == D + 1) begin
              m_pressed[ch] = 1'b0; m_long[ch] = 1'b0;
              opp_run[ch] = 0; ev = K_REL;
            end
          end
          if (ev >= 0) begin
            exp_q.push_back('{cyc, ch, ev});
            pulse_now[ev*N + ch] = 1'b1;
          end
        end
      end
      m_pulse_prev = pulse_now;
      for (int ch = 0; ch < N; ch++) m_level[ch] = m_pressed[ch];
    end
  end

  // Monitor: pops this cycle's expected events and compares them with the
  // pulses the DUT presents, plus level and sticky flags every cycle.
  initial begin
    forever begin
      logic [FW-1:0] dut_p, exp_p;
      @(negedge clk);
      if (mon_en) begin
        dut_p = {bus.key_long, bus.key_rel, bus.key_press};
        exp_p = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          evt_t e;
          e = exp_q.pop_front();
          if (e.cyc == cyc) exp_p[e.kind*N + e.ch] = 1'b1;
          else chk("stale_event_cycle", 64'(e.cyc), 64'(cyc));
        end
        for (int k = 0; k < 3; k++)
          for (int ch = 0; ch < N; ch++)
            if (dut_p[k*N + ch] === 1'b1) begin
              last_cyc[k][ch] = cyc;
              cnt_pulse[k][ch]++;
            end
        chk("pulses{long,rel,press}", 64'(dut_p), 64'(exp_p));
        chk("key_level", 64'(bus.key_level), 64'(m_level));
        chk("evt_flags", 64'(bus.evt_flags), 64'(m_flags));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr(input logic [FW-1:0] m);
    bus.evt_clr = m;
    step(1);
    bus.evt_clr = '0;
  endtask

  initial begin
    int t, p0, seen, rc;
    int seg [N];
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < N; ch++) begin
        last_cyc[k][ch] = -1; cnt_pulse[k][ch] = 0;
      end
    rst = 1'b1;
    bus.key_n   = '1;
    bus.evt_clr = '0;
    step(3);
    mon_en = 1'b1;
    chk("reset_flags", 64'(bus.evt_flags), 64'd0);
    chk("reset_level", 64'(bus.key_level), 64'd0);
    rst = 1'b0;

    // 1: idle after reset, no pulses
    step(100);
    chk("idle_press_count", 64'(cnt_pulse[K_PRESS][0] + cnt_pulse[K_PRESS][1]), 64'd0);

    // 2: key 0 held 20 cycles
    t = cyc + 1;
    bus.key_n[0] = 1'b0;
    step(20);
    bus.key_n[0] = 1'b1;
    step(20);
    chk("k0_press_latency", 64'(last_cyc[K_PRESS][0] - t), 64'd10);
    chk("k0_rel_latency", 64'(last_cyc[K_REL][0] - t), 64'd30);

    // 3: bouncing key 0, toggling every 3 cycles
    p0 = cnt_pulse[K_PRESS][0];
    for (int i = 0; i < 10; i++) begin
      bus.key_n[0] = ~bus.key_n[0];
      step(3);
    end
    bus.key_n[0] = 1'b1;
    step(20);
    chk("bounce_no_press", 64'(cnt_pulse[K_PRESS][0] - p0), 64'd0);

    // 4: key 1 held 60 cycles, long press, then flag clear
    pulse_clr('1);
    t = cyc + 1;
    bus.key_n[1] = 1'b0;
    step(60);
    bus.key_n[1] = 1'b1;
    step(20);
    chk("k1_press_at", 64'(last_cyc[K_PRESS][1] - t), 64'd10);
    chk("k1_long_at", 64'(last_cyc[K_LONG][1] - t), 64'd50);
    chk("k1_rel_at", 64'(last_cyc[K_REL][1] - t), 64'd70);
    chk("flags_after_long", 64'(bus.evt_flags), 64'b10_10_10);
    pulse_clr(6'b00_00_10);
    chk("flags_after_clr", 64'(bus.evt_flags), 64'b10_10_00);

    // 5: 3-cycle release glitch while PRESSED delays the long press by 3
    rc = cnt_pulse[K_REL][0];
    t = cyc + 1;
    bus.key_n[0] = 1'b0;
    step(20);
    bus.key_n[0] = 1'b1;
    step(3);
    bus.key_n[0] = 1'b0;
    step(60);
    chk("glitch_no_rel", 64'(cnt_pulse[K_REL][0] - rc), 64'd0);
    chk("glitch_long_delay", 64'(last_cyc[K_LONG][0] - last_cyc[K_PRESS][0]), 64'(L + 3));
    bus.key_n[0] = 1'b1;
    step(20);

    // 6: clear coinciding with the press pulse, then reset mid REL_WAIT
    pulse_clr('1);
    bus.key_n[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1);
      if (bus.key_press[0] === 1'b1) seen = 1;
    end
    chk("press_seen_for_clr", 64'(seen), 64'd1);
    pulse_clr(6'b00_00_01);
    chk("set_wins_over_clr", 64'(bus.evt_flags[0]), 64'd1);
    step(10);
    bus.key_n[0] = 1'b1;
    rc = cnt_pulse[K_REL][0];
    step(5);
    rst = 1'b1;
    step(1);
    chk("rst_level", 64'(bus.key_level), 64'd0);
    chk("rst_pulses", 64'({bus.key_long, bus.key_rel, bus.key_press}), 64'd0);
    chk("rst_flags", 64'(bus.evt_flags), 64'd0);
    rst = 1'b0;
    step(30);
    chk("rst_no_rel", 64'(cnt_pulse[K_REL][0] - rc), 64'd0);

    // randomized traffic on both keys
    for (int ch = 0; ch < N; ch++) seg[ch] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (seg[ch] == 0) begin
          int r;
          bus.key_n[ch] = ~bus.key_n[ch];
          r = $urandom_range(0, 9);
          seg[ch] = (r < 5) ? $urandom_range(1, 6) :
                    (r < 8) ? $urandom_range(8, 25) : $urandom_range(40, 70);
        end
        seg[ch]--;
      end
      bus.evt_clr = ($urandom_range(0, 7) == 0) ? FW'($urandom) : '0;
      rst = (c == 1200);
      step(1);
    end
    rst = 1'b0;
    bus.evt_clr = '0;
    bus.key_n = '1;
    step(40);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
